// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART constants: clock frequency, baud divisors, transmit state encoding
// and the baud-select to divisor lookup used by uart_tx_ctrl.
package uart_tx_ctrl_pkg;

    localparam int FREQUENCY       = 50_000_000;
    localparam int UART_9600_CNT   = FREQUENCY / 9600;
    localparam int UART_19200_CNT  = FREQUENCY / 19200;
    localparam int UART_38400_CNT  = FREQUENCY / 38400;
    localparam int UART_57600_CNT  = FREQUENCY / 57600;
    localparam int UART_115200_CNT = FREQUENCY / 115200;

    // Wide enough for the slowest divisor (5208 at 50 MHz).
    localparam int UART_CNT_SIZE   = 13;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        B9600   = 3'd0,
        B19200  = 3'd1,
        B38400  = 3'd2,
        B57600  = 3'd3,
        B115200 = 3'd4
    } baud_sel_t;

    // Unlisted select codes fall back to the slowest rate.
    function automatic logic [UART_CNT_SIZE-1:0] uart_div(input baud_sel_t sel);
        case (sel)
            B19200:  return UART_CNT_SIZE'(UART_19200_CNT);
            B38400:  return UART_CNT_SIZE'(UART_38400_CNT);
            B57600:  return UART_CNT_SIZE'(UART_57600_CNT);
            B115200: return UART_CNT_SIZE'(UART_115200_CNT);
            default: return UART_CNT_SIZE'(UART_9600_CNT);
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-write and baud-select handshake between the UART peripheral (master)
// and the transmit controller (slave).
interface uart_tx_ctrl_if;
    logic [2:0] baud_sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output baud_sel,
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  baud_sel,
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_ctrl_fifo.sv
// uart_tx_fifo: small synchronous FIFO for transmit bytes; pointers carry one
// extra MSB so full and empty are distinguished without a counter.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the cleared pointers mark every entry stale.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit controller. Optional build macro UART_TX_FIFO_EN swaps the
// single holding register for a FIFO_DEPTH-entry FIFO.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   TX_IDLE  | line high, waiting for a buffered byte
//   TX_START | start bit (low) for div_q cycles
//   TX_DATA  | eight data bits LSB first, div_q cycles each
//   TX_STOP  | stop bit (high); chains into TX_START if buffered
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CNT_W      = UART_CNT_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus,
    output logic           busy,
    output logic           tx
);
    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_sel;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             cnt_last;
    logic             push;
    logic             pop;
    logic             buf_valid;
    logic [7:0]       buf_data;

    assign push     = bus.in_valid && bus.in_ready;
    assign cnt_last = (cnt == div_q - CNT_W'(1));
    assign div_sel  = CNT_W'(uart_div(baud_sel_t'(bus.baud_sel)));
    // A byte leaves the buffer when a frame is started, from IDLE or chained from STOP.
    assign pop      = buf_valid && ((state == TX_IDLE) || ((state == TX_STOP) && cnt_last));
    assign busy     = (state != TX_IDLE) || buf_valid;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .pop_data  (buf_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign buf_valid    = !fifo_empty;
    assign bus.in_ready = !fifo_full && !rst;
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // in_ready is low while full, so a push and a pop never meet in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.in_data;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_valid    = hold_valid;
    assign buf_data     = hold_data;
    assign bus.in_ready = !hold_valid && !rst;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            div_q   <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            tx      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (pop) begin
                        shift <= buf_data;
                        div_q <= div_sel;
                        state <= TX_START;
                        tx    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        bit_cnt <= 3'd0;
                        state   <= TX_DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (pop) begin
                            shift <= buf_data;
                            div_q <= div_sel;
                            state <= TX_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: bytes accepted on the handshake are
// queued in a reference model and the serial line is compared bit-by-bit.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic tx;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] model_q [$];

    // Bit period in clocks for a 50 MHz clock, straight from the nominal baud rate.
    function automatic int div_for(input int sel);
        int rate;
        case (sel)
            1:       rate = 19200;
            2:       rate = 38400;
            3:       rate = 57600;
            4:       rate = 115200;
            default: rate = 9600;
        endcase
        return 50_000_000 / rate;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 60000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL push_timeout byte=%h in_ready=%b expected 1", b, bus.in_ready);
        else begin
            n_pass++;
            model_q.push_back(b);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit ok);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (tx !== 1'b0 && c < limit);
        n_checks++;
        if (tx !== 1'b0) begin
            $display("FAIL start_timeout tx=%b expected 0 within %0d cycles", tx, limit);
            ok = 1'b0;
        end else begin
            n_pass++;
            ok = 1'b1;
        end
    endtask

    // Called at the negedge of the first start-bit cycle; ends nbits*div cycles later.
    task automatic check_frame(input int div, input int nbits);
        logic [7:0] b;
        logic [9:0] frame;
        int bad;
        int busy_bad;
        n_checks++;
        if (model_q.size() == 0) begin
            $display("FAIL frame_unexpected queue_size=0 expected a queued byte");
            b = 8'h00;
        end else begin
            n_pass++;
            b = model_q.pop_front();
        end
        frame    = {1'b1, b, 1'b0};
        busy_bad = 0;
        for (int k = 0; k < nbits; k++) begin
            bad = 0;
            for (int c = 0; c < div; c++) begin
                if (tx !== frame[k]) bad++;
                if (busy !== 1'b1) busy_bad++;
                @(negedge clk);
            end
            n_checks++;
            if (bad != 0) $display("FAIL frame_bit byte=%h bit=%0d div=%0d wrong_cycles=%0d expected 0", b, k, div, bad);
            else n_pass++;
        end
        n_checks++;
        if (busy_bad != 0) $display("FAIL frame_busy byte=%h busy_low_cycles=%0d expected 0", b, busy_bad);
        else n_pass++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad_tx, bad_busy, bad_rdy;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.baud_sel = 3'd4;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL rst_tx tx=%b expected 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy busy=%b expected 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready in_ready=%b expected 0", bus.in_ready); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        bad_tx = 0; bad_busy = 0; bad_rdy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (bus.in_ready !== 1'b1) bad_rdy++;
        end
        n_checks++; if (bad_tx != 0) $display("FAIL idle_tx bad_cycles=%0d expected 0", bad_tx); else n_pass++;
        n_checks++; if (bad_busy != 0) $display("FAIL idle_busy bad_cycles=%0d expected 0", bad_busy); else n_pass++;
        n_checks++; if (bad_rdy != 0) $display("FAIL idle_in_ready bad_cycles=%0d expected 0", bad_rdy); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_a5();
        bus.baud_sel = 3'd4;
        push_byte(8'hA5);
        @(negedge clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL latency_n1 tx=%b expected 1", tx); else n_pass++;
        @(negedge clk);
        n_checks++; if (tx !== 1'b0) $display("FAIL latency_n2 tx=%b expected 0", tx); else n_pass++;
        check_frame(div_for(4), 10);
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end busy=%b expected 0", busy); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_end tx=%b expected 1", tx); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.baud_sel = 3'd4;
        @(posedge clk);
        #1;
        fork
            begin
                push_byte(8'h00);
                push_byte(8'hFF);
                @(negedge clk);
                n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full_ready in_ready=%b expected 0", bus.in_ready); else n_pass++;
                push_byte(8'h3C);
            end
            begin
                wait_start(100, ok);
                if (ok) begin
                    check_frame(div_for(4), 10);
                    check_frame(div_for(4), 10);
                    check_frame(div_for(4), 10);
                end
            end
        join
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end busy=%b expected 0", busy); else n_pass++;
    endtask

    task automatic test_baud_change();
        bit ok;
        bus.baud_sel = 3'd4;
        @(posedge clk);
        #1;
        fork
            begin
                push_byte(8'h5A);
                push_byte(8'hC3);
                repeat (1000) @(posedge clk);
                #1 bus.baud_sel = 3'd0;
            end
            begin
                wait_start(100, ok);
                if (ok) begin
                    check_frame(div_for(4), 10);
                    check_frame(div_for(0), 2);
                end
            end
        join
        apply_reset();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int bad_tx, bad_busy;
        bus.baud_sel = 3'd4;
        @(posedge clk);
        #1;
        fork
            begin
                push_byte(8'h96);
                push_byte(8'h69);
            end
            begin
                wait_start(100, ok);
                if (ok) repeat (4 * div_for(4) + 200) @(negedge clk);
            end
        join
        n_checks++; if (tx !== 1'b0) $display("FAIL pre_reset_tx tx=%b expected 0", tx); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL async_rst_tx tx=%b expected 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy busy=%b expected 0", busy); else n_pass++;
        model_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bad_tx = 0; bad_busy = 0;
        repeat (3000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        n_checks++; if (bad_tx != 0) $display("FAIL post_rst_tx bad_cycles=%0d expected 0", bad_tx); else n_pass++;
        n_checks++; if (bad_busy != 0) $display("FAIL post_rst_busy bad_cycles=%0d expected 0", bad_busy); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit ok;
        int sel;
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            sel = $urandom_range(3, 4);
            b   = 8'($urandom);
            bus.baud_sel = 3'(sel);
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
            fork
                push_byte(b);
                begin
                    wait_start(100, ok);
                    if (ok) check_frame(div_for(sel), 10);
                end
            join
            n_checks++; if (busy !== 1'b0) $display("FAIL random_busy_end iter=%0d busy=%b expected 0", i, busy); else n_pass++;
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst();
        bit ok;
        bus.baud_sel = 3'd4;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i <= 5; i++) push_byte(8'(i));
                @(negedge clk);
                n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL fifo_full_ready in_ready=%b expected 0", bus.in_ready); else n_pass++;
            end
            begin
                wait_start(100, ok);
                if (ok) for (int i = 0; i < 5; i++) check_frame(div_for(4), 10);
            end
        join
        n_checks++; if (busy !== 1'b0) $display("FAIL fifo_busy_end busy=%b expected 0", busy); else n_pass++;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_baud_change();
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_FIFO_EN
        test_fifo_burst();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
